otter_cu_fsm: RTL
=================

# otter_cu_fsm

Multicycle control-unit state machine for the OTTER RV32I core. It sequences each instruction through fetch, execute, optional writeback and optional interrupt entry. It generates the write/read enables for the PC, register file, memory and CSR file. It also drives `int_taken` into the combinational control-unit decoder, which then selects the trap vector on `pcSource`. It sits beside the decoder, consuming the same opcode/funct3 fields of the instruction register.

## Interface
Parameters:
- `INSTRET_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ir6_0`  in  7  opcode field of the current instruction.
- `ir14_12`  in  3  funct3 field.
- `intr`  in  1  level-sensitive external interrupt request.
- `csr_mie`  in  1  mstatus.MIE from the CSR file.
- `pc_write`  out  1  PC register load enable.
- `reg_write`  out  1  register-file write enable.
- `mem_rden1`  out  1  instruction-memory read enable.
- `mem_rden2`  out  1  data-memory read enable.
- `mem_we2`  out  1  data-memory write enable.
- `csr_we`  out  1  CSR write enable.
- `int_taken`  out  1  interrupt entry, to the decoder and the CSR file.
- `mret_exec`  out  1  MRET executing, so the CSR file restores MIE.
- `core_reset`  out  1  synchronous clear to the PC and register file.
- `instret`  out  INSTRET_W  count of retired instructions.

## Operation
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR. Held in a registered enum.
- The `instret` register is the only other storage.
- Outputs are combinational from the state and the ir fields. Every output not listed for a state is 0.
- ST_INIT:
  - Outputs: `core_reset`=1.
  - Next state: ST_FETCH.
- ST_FETCH:
  - Outputs: `mem_rden1`=1.
  - Next state: ST_EXEC.
- ST_EXEC, outputs by opcode:
  - load (0000011): `mem_rden2`=1, then go to ST_WB.
  - store (0100011): `pc_write`=1, `mem_we2`=1.
  - branch (1100011): `pc_write`=1.
  - R, I-alu, lui, auipc, jal, jalr: `pc_write`=1, `reg_write`=1.
  - SYSTEM (1110011), funct3=000 (MRET): `pc_write`=1, `mret_exec`=1.
  - SYSTEM, funct3 001/010/011 (CSRRW/CSRRS/CSRRC): `pc_write`=1, `reg_write`=1, `csr_we`=1.
  - Any other opcode or funct3: `pc_write`=1 only; executes as a NOP.
- ST_EXEC, next state for non-load opcodes: ST_INTR if `intr && csr_mie`, else ST_FETCH.
- ST_WB:
  - Outputs: `reg_write`=1, `pc_write`=1.
  - Next state: ST_INTR if `intr && csr_mie`, else ST_FETCH.
- ST_INTR:
  - Outputs: `int_taken`=1, `pc_write`=1.
  - Next state: ST_FETCH.
- Retire point: a cycle where `pc_write`=1 and the state is not ST_INTR. On a retire point, `instret` increments by 1.
- `instret` wraps modulo 2^INSTRET_W. An MRET retires and counts.
- Interrupt sampling:
  - `intr` is sampled only in the final cycle of an instruction.
  - An interrupt is never taken between ST_FETCH and ST_EXEC.
  - `intr` and MRET in the same cycle: MRET completes, then ST_INTR is entered. `csr_mie` is the pre-MRET value.

## Timing
- While `rst_n`=0, regardless of `clk`:
  - state = ST_INIT and `instret` = 0.
  - Outputs: `core_reset`=1, all other outputs 0.
- First edge after `rst_n` rises: ST_INIT → ST_FETCH. `core_reset` is high for exactly one cycle after release.
- Latency:
  - Non-load instruction: 2 cycles.
  - Load: 3 cycles.
  - Interrupt entry: +1 cycle after the instruction it follows.
- `rst_n` asserted mid-instruction: immediate return to ST_INIT; no partial write is completed. Enables drop asynchronously.
- `intr` deasserted before the final cycle: no trap. No latching of `intr`.

## Configuration
- `OTTER_CU_INTR_EN` defined: ST_INTR exists and interrupts behave as above.
- Undefined:
  - ST_INTR and its transitions are removed.
  - `int_taken` is tied 0.
  - `intr` and `csr_mie` are unused.
  - ST_EXEC and ST_WB always go to ST_FETCH.

## Structure
- Package `otter_pkg`:
  - the state enum `cu_state_t`;
  - opcode localparams: OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM;
  - funct3 localparams for the SYSTEM opcode.
- Sub-module `otter_instret_ctr` (parameter INSTRET_W): asynchronous clear, increment-enable counter.

## Test plan
- Reset release → `core_reset`=1 for 1 cycle, then `mem_rden1`=1, then the EXEC enables. `instret` stays 0 until the first retire.
- Sequence add (0110011), lw (0000011), sw (0100011) → cycle counts 2/3/2:
  - `reg_write` in EXEC for add.
  - `reg_write` in WB for lw.
  - `mem_we2` for sw.
  - `instret`=3 afterwards.
- beq (1100011) → `pc_write`=1, `reg_write`=0. csrrs (1110011, f3=010) → `csr_we`=1, `reg_write`=1.
- `intr`=1, `csr_mie`=1 during EXEC of addi → ST_INTR follows: `int_taken`=1, `pc_write`=1, `instret` unchanged. `csr_mie`=0 → no trap.
- MRET with `intr`=1, `csr_mie`=1 → `mret_exec`=1 in EXEC, `int_taken`=1 in the next cycle.
- `rst_n` pulled low in ST_WB of lw → `reg_write` drops at once, `instret`=0. Macro undefined → `int_taken` is never 1 under any `intr` stimulus.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER multicycle control unit.
// With OTTER_CU_INTR_EN defined, the interrupt-entry state is part of the state enum.
package otter_pkg;

  // Control-unit states. ST_INTR exists only when interrupts are built in.
`ifdef OTTER_CU_INTR_EN
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;
`else
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3
  } cu_state_t;
`endif

  // RV32I major opcodes (ir[6:0]).
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 values under OPC_SYSTEM.
  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;

  // True for the register-form CSR access instructions.
  function automatic logic is_csr_f3(input logic [2:0] f3);
    return (f3 == F3_CSRRW) || (f3 == F3_CSRRS) || (f3 == F3_CSRRC);
  endfunction

  // True for opcodes that write an integer result back in ST_EXEC.
  function automatic logic is_alu_like(input logic [6:0] opc);
    return (opc == OPC_OP)  || (opc == OPC_OPIMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/otter_instret_ctr.sv
// Retired-instruction counter: asynchronous clear, increments when en is high,
// wraps modulo 2^INSTRET_W.
module otter_instret_ctr #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [INSTRET_W-1:0] count
);

  localparam logic [INSTRET_W-1:0] ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  logic [INSTRET_W-1:0] count_reg;

  // Count one per enabled cycle; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control-unit FSM: INIT -> FETCH -> EXEC [-> WB] [-> INTR].
// Optional feature macro: OTTER_CU_INTR_EN (interrupt entry state and int_taken).
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           ir6_0,
  input  logic [2:0]           ir14_12,
  input  logic                 intr,
  input  logic                 csr_mie,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 mem_rden1,
  output logic                 mem_rden2,
  output logic                 mem_we2,
  output logic                 csr_we,
  output logic                 int_taken,
  output logic                 mret_exec,
  output logic                 core_reset,
  output logic [INSTRET_W-1:0] instret
);

  cu_state_t state_reg;
  cu_state_t state_next;
  logic      retire;

`ifdef OTTER_CU_INTR_EN
  // Interrupt is taken only at the last cycle of an instruction.
  logic take_intr;
  assign take_intr = intr & csr_mie;
`else
  logic unused_intr_inputs;
  assign unused_intr_inputs = intr ^ csr_mie;
`endif

  // State register; reset forces ST_INIT immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = ST_FETCH;
    case (state_reg)
      ST_INIT:  state_next = ST_FETCH;
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC: begin
        if (ir6_0 == OPC_LOAD) begin
          state_next = ST_WB;
        end else begin
`ifdef OTTER_CU_INTR_EN
          state_next = take_intr ? ST_INTR : ST_FETCH;
`else
          state_next = ST_FETCH;
`endif
        end
      end
      ST_WB: begin
`ifdef OTTER_CU_INTR_EN
        state_next = take_intr ? ST_INTR : ST_FETCH;
`else
        state_next = ST_FETCH;
`endif
      end
`ifdef OTTER_CU_INTR_EN
      ST_INTR:  state_next = ST_FETCH;
`endif
      default:  state_next = ST_INIT;
    endcase
  end

  // Output decode from state and instruction fields.
  always_comb begin
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_rden1  = 1'b0;
    mem_rden2  = 1'b0;
    mem_we2    = 1'b0;
    csr_we     = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;
    core_reset = 1'b0;
    case (state_reg)
      ST_INIT:  core_reset = 1'b1;
      ST_FETCH: mem_rden1  = 1'b1;
      ST_EXEC: begin
        if (ir6_0 == OPC_LOAD) begin
          mem_rden2 = 1'b1;
        end else if (ir6_0 == OPC_STORE) begin
          pc_write = 1'b1;
          mem_we2  = 1'b1;
        end else if (ir6_0 == OPC_BRANCH) begin
          pc_write = 1'b1;
        end else if (is_alu_like(ir6_0)) begin
          pc_write  = 1'b1;
          reg_write = 1'b1;
        end else if (ir6_0 == OPC_SYSTEM && ir14_12 == F3_MRET) begin
          pc_write  = 1'b1;
          mret_exec = 1'b1;
        end else if (ir6_0 == OPC_SYSTEM && is_csr_f3(ir14_12)) begin
          pc_write  = 1'b1;
          reg_write = 1'b1;
          csr_we    = 1'b1;
        end else begin
          // Unrecognised opcode/funct3 retires as a NOP.
          pc_write = 1'b1;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
`ifdef OTTER_CU_INTR_EN
      ST_INTR: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
      end
`endif
      default: core_reset = 1'b1;
    endcase
  end

  // A PC update outside of interrupt entry marks a retired instruction.
`ifdef OTTER_CU_INTR_EN
  assign retire = pc_write & (state_reg != ST_INTR);
`else
  assign retire = pc_write;
`endif

  otter_instret_ctr #(
    .INSTRET_W (INSTRET_W)
  ) u_instret_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire),
    .count (instret)
  );

endmodule
